frame_scan_scheduler: RTL and testbench

Owns the single read port of the 320x240 frame-buffer BRAM and shares it between the VGA display path and the red-pixel direction analysis path. When capture signals a finished frame, the block sweeps analysis addresses 0..W*H-1 in raster order through the shared port. VGA reads always take priority and stall the sweep. Returned pixels are tagged and routed back to the correct requester. Frame start/done handshakes and a dropped-frame counter are provided for the control logic.

---
 rtl/frame_scan_scheduler.sv | 171 +++++++++++++++++
 tb/tb_frame_scan_scheduler.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_scan_scheduler.sv
// Shares the frame-buffer BRAM read port between VGA reads and a raster sweep for
// the analysis path. VGA pre-empts the sweep; a tag pipeline routes read data back.
module frame_scan_scheduler #(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int unsigned PIXEL_BITS   = 12,
  parameter int unsigned RD_LATENCY   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_ready,
  input  logic                  vga_req,
  input  logic [ADDR_BITS-1:0]  vga_addr,
  output logic                  vga_valid,
  output logic [PIXEL_BITS-1:0] vga_rddata,
  output logic [ADDR_BITS-1:0]  bram_rdaddress,
  input  logic [PIXEL_BITS-1:0] bram_rddata,
  output logic                  an_valid,
  output logic [ADDR_BITS-1:0]  an_addr,
  output logic [PIXEL_BITS-1:0] an_rddata,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            frames_dropped
);

  localparam int unsigned NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned TAG_DEPTH  = RD_LATENCY + 1;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_PIXELS - 1);
  localparam logic OWNER_VGA = 1'b0;
  localparam logic OWNER_AN  = 1'b1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic                 valid;
    logic                 owner;
    logic [ADDR_BITS-1:0] addr;
  } tag_t;

  state_t               state_q, state_d;
  logic                 pending_q, pending_d;
  logic [ADDR_BITS-1:0] scan_cnt_q, scan_cnt_d;
  logic [7:0]           dropped_d;
  logic [ADDR_BITS-1:0] rdaddr_d;
  tag_t                 tag_in;
  tag_t                 tag_q [TAG_DEPTH];
  tag_t                 tag_out;
  logic                 an_inflight;

  assign tag_out = tag_q[RD_LATENCY];

  // Any analysis read still travelling through the BRAM latency
  always_comb begin
    an_inflight = 1'b0;
    for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
      an_inflight = an_inflight | (tag_q[i].valid & (tag_q[i].owner == OWNER_AN));
    end
  end

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    scan_cnt_d = scan_cnt_q;
    dropped_d  = frames_dropped;
    rdaddr_d   = bram_rdaddress;
    tag_in     = '0;

    if (vga_req) begin
      rdaddr_d     = vga_addr;
      tag_in.valid = 1'b1;
      tag_in.owner = OWNER_VGA;
      tag_in.addr  = vga_addr;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_ready || pending_q) begin
          state_d    = SCAN;
          pending_d  = 1'b0;
          scan_cnt_d = '0;
        end
      end
      SCAN: begin
        if (!vga_req) begin
          rdaddr_d     = scan_cnt_q;
          tag_in.valid = 1'b1;
          tag_in.owner = OWNER_AN;
          tag_in.addr  = scan_cnt_q;
          if (scan_cnt_q == LAST_ADDR) begin
            state_d = DRAIN;
          end else begin
            scan_cnt_d = scan_cnt_q + ADDR_BITS'(1);
          end
        end
      end
      DRAIN: begin
        if (!an_inflight) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A second frame waiting behind the current one is remembered; any more are counted
    if (frame_ready && ((state_q != IDLE) || pending_q)) begin
      if (!pending_q) begin
        pending_d = 1'b1;
      end else if (frames_dropped != 8'hFF) begin
        dropped_d = frames_dropped + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= 1'b0;
      scan_cnt_q     <= '0;
      frames_dropped <= '0;
      bram_rdaddress <= '0;
      busy           <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      scan_cnt_q     <= scan_cnt_d;
      frames_dropped <= dropped_d;
      bram_rdaddress <= rdaddr_d;
      busy           <= (state_d != IDLE);
      frame_done     <= (state_d == DONE);
    end
  end

  // Tag pipeline tracks each read until its data leaves the BRAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < TAG_DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_valid  <= 1'b0;
      vga_rddata <= '0;
      an_valid   <= 1'b0;
      an_addr    <= '0;
      an_rddata  <= '0;
    end else begin
      vga_valid <= tag_out.valid & (tag_out.owner == OWNER_VGA);
      an_valid  <= tag_out.valid & (tag_out.owner == OWNER_AN);
      if (tag_out.valid && (tag_out.owner == OWNER_VGA)) begin
        vga_rddata <= bram_rddata;
      end
      if (tag_out.valid && (tag_out.owner == OWNER_AN)) begin
        an_rddata <= bram_rddata;
        an_addr   <= tag_out.addr;
      end
    end
  end

endmodule

// File: tb/tb_frame_scan_scheduler.sv
// Bench for frame_scan_scheduler on an 8x4 frame: BRAM model, latency-line VGA
// expectations and an address-sequence reference for the analysis sweep.
`timescale 1ns/1ps
module tb_frame_scan_scheduler;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int NPIX = W * H;
  localparam int AW   = $clog2(NPIX);
  localparam int PB   = 12;
  localparam int RL   = 1;
  localparam int LAT  = RL + 1;
  localparam int OUTW = 2 * PB + 2 * AW + 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_ready = 1'b0;
  logic          vga_req = 1'b0;
  logic [AW-1:0] vga_addr = '0;
  logic          vga_valid;
  logic [PB-1:0] vga_rddata;
  logic [AW-1:0] bram_rdaddress;
  logic [PB-1:0] bram_rddata;
  logic          an_valid;
  logic [AW-1:0] an_addr;
  logic [PB-1:0] an_rddata;
  logic          busy;
  logic          frame_done;
  logic [7:0]    frames_dropped;

  logic [PB-1:0] mem [NPIX];
  logic [PB-1:0] rd_pipe [RL];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic          vq_v [LAT+1];
  logic [AW-1:0] vq_a [LAT+1];
  int an_exp, an_cnt, an_bad, vga_bad, first_an_cyc, last_an_cyc;
  int done_cnt, done_cyc, short_sweeps;

  always #10 clk = ~clk;

  frame_scan_scheduler #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .ADDR_BITS   (AW),
    .PIXEL_BITS  (PB),
    .RD_LATENCY  (RL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_ready   (frame_ready),
    .vga_req       (vga_req),
    .vga_addr      (vga_addr),
    .vga_valid     (vga_valid),
    .vga_rddata    (vga_rddata),
    .bram_rdaddress(bram_rdaddress),
    .bram_rddata   (bram_rddata),
    .an_valid      (an_valid),
    .an_addr       (an_addr),
    .an_rddata     (an_rddata),
    .busy          (busy),
    .frame_done    (frame_done),
    .frames_dropped(frames_dropped)
  );

  // BRAM read port with RL cycles from registered address to data
  always @(posedge clk) begin
    rd_pipe[0] <= mem[bram_rdaddress];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bram_rddata = rd_pipe[RL-1];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [OUTW-1:0] all_outs();
    return {vga_valid, vga_rddata, bram_rdaddress, an_valid, an_addr, an_rddata,
            busy, frame_done, frames_dropped};
  endfunction

  task automatic fill_mem();
    for (int i = 0; i < NPIX; i++) mem[i] = PB'($urandom);
  endtask

  task automatic clear_model();
    for (int i = 0; i <= LAT; i++) begin
      vq_v[i] = 1'b0;
      vq_a[i] = '0;
    end
    an_exp = 0;
  endtask

  task automatic clear_obs();
    an_cnt = 0; an_bad = 0; vga_bad = 0; first_an_cyc = 0; last_an_cyc = 0;
    done_cnt = 0; done_cyc = 0; short_sweeps = 0;
  endtask

  // One clock: drive inputs, then observe outputs just after the edge
  task automatic step(input logic fr, input logic vr, input logic [AW-1:0] va);
    frame_ready = fr;
    vga_req     = vr;
    vga_addr    = va;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = LAT; i > 0; i--) begin
      vq_v[i] = vq_v[i-1];
      vq_a[i] = vq_a[i-1];
    end
    vq_v[0] = vr;
    vq_a[0] = va;
    if (vga_valid !== vq_v[LAT]) vga_bad++;
    else if (vq_v[LAT] && (vga_rddata !== mem[vq_a[LAT]])) vga_bad++;
    if (an_valid) begin
      if (an_cnt == 0) first_an_cyc = cyc;
      if (an_exp >= NPIX || an_addr !== AW'(an_exp) || an_rddata !== mem[an_addr]) an_bad++;
      an_exp++;
      an_cnt++;
      last_an_cyc = cyc;
    end
    if (frame_done) begin
      if (an_exp != NPIX) short_sweeps++;
      an_exp = 0;
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic run_to_done(input int budget, output bit timed_out);
    int start;
    start = done_cnt;
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      step(1'b0, 1'b0, '0);
      if (done_cnt != start) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    frame_ready = 1'b0;
    vga_req = 1'b0;
    clear_model();
    clear_obs();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (all_outs() !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_outs());
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      checks++;
      if (all_outs() !== '0) begin
        errors++; $display("FAIL reset_idle cycle %0d: got %h want 0", i, all_outs());
      end
    end
  endtask

  task automatic test_sweep();
    int c0;
    bit to;
    clear_obs();
    step(1'b1, 1'b0, '0);
    c0 = cyc;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy_rise: got %b want 1", busy); end
    run_to_done(200, to);
    checks++;
    if (to) begin errors++; $display("FAIL sweep_timeout: got timeout want frame_done"); end
    checks++;
    if (an_cnt != NPIX || an_bad != 0) begin
      errors++; $display("FAIL sweep_pixels: got %0d pixels (%0d bad) want %0d (0 bad)", an_cnt, an_bad, NPIX);
    end
    checks++;
    if (first_an_cyc != c0 + 1 + LAT || last_an_cyc - first_an_cyc != NPIX - 1) begin
      errors++; $display("FAIL sweep_timing: got first %0d last %0d want first %0d last %0d",
                         first_an_cyc - c0, last_an_cyc - c0, 1 + LAT, LAT + NPIX);
    end
    checks++;
    if (done_cyc != last_an_cyc + 1 || done_cnt != 1 || short_sweeps != 0) begin
      errors++; $display("FAIL sweep_frame_done: got cycle %0d count %0d want cycle %0d count 1",
                         done_cyc - c0, done_cnt, last_an_cyc + 1 - c0);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL sweep_busy_in_done: got %b want 1", busy); end
    step(1'b0, 1'b0, '0);
    checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL sweep_busy_fall: got busy %b done %b want 0 0", busy, frame_done);
    end
    checks++;
    if (vga_bad != 0) begin errors++; $display("FAIL sweep_vga_quiet: got %0d bad want 0", vga_bad); end
  endtask

  task automatic test_vga_interleave();
    int c0;
    bit to;
    repeat (3) step(1'b0, 1'b0, '0);
    fill_mem();
    clear_obs();
    step(1'b1, 1'b0, '0);
    c0 = cyc;
    to = 1'b1;
    for (int k = 1; k < 400; k++) begin
      step(1'b0, (k % 2 == 1), AW'($urandom));
      if (done_cnt != 0) begin to = 1'b0; break; end
    end
    checks++;
    if (to) begin errors++; $display("FAIL interleave_timeout: got timeout want frame_done"); end
    checks++;
    if (vga_bad != 0) begin errors++; $display("FAIL interleave_vga: got %0d bad returns want 0", vga_bad); end
    checks++;
    if (an_cnt != NPIX || an_bad != 0 || short_sweeps != 0) begin
      errors++; $display("FAIL interleave_an: got %0d pixels (%0d bad) want %0d (0 bad)", an_cnt, an_bad, NPIX);
    end
    checks++;
    if (done_cyc != c0 + 2 * NPIX + LAT + 1) begin
      errors++; $display("FAIL interleave_duration: got %0d want %0d", done_cyc - c0, 2 * NPIX + LAT + 1);
    end
    repeat (3) step(1'b0, 1'b0, '0);
  endtask

  task automatic test_vga_stall();
    int stall_an;
    bit to;
    stall_an = 0;
    clear_obs();
    step(1'b1, 1'b0, '0);
    for (int k = 1; k <= 113; k++) begin
      step(1'b0, (k >= 11 && k <= 110), AW'($urandom));
      if (k >= 13 && k <= 112 && an_valid) stall_an++;
      if (k == 110) begin
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
      end
      if (k == 113) begin
        checks++;
        if (an_valid !== 1'b1 || an_addr !== AW'(10)) begin
          errors++; $display("FAIL stall_resume: got valid %b addr %0d want valid 1 addr 10", an_valid, an_addr);
        end
      end
    end
    checks++;
    if (stall_an != 0) begin errors++; $display("FAIL stall_an_quiet: got %0d an_valid want 0", stall_an); end
    run_to_done(200, to);
    checks++;
    if (to || an_cnt != NPIX || an_bad != 0 || vga_bad != 0 || short_sweeps != 0) begin
      errors++; $display("FAIL stall_complete: got timeout %b pixels %0d bad %0d vga_bad %0d want 0 %0d 0 0",
                         to, an_cnt, an_bad, vga_bad, NPIX);
    end
  endtask

  task automatic test_drop_frames();
    bit to1, to2;
    clear_obs();
    step(1'b1, 1'b0, '0);
    for (int k = 1; k <= 12; k++) step((k % 4 == 0), 1'b0, '0);
    checks++;
    if (frames_dropped !== 8'd2) begin errors++; $display("FAIL drop_three: got %0d want 2", frames_dropped); end
    run_to_done(200, to1);
    step(1'b0, 1'b0, '0);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL drop_idle_gap: got busy %b want 0", busy); end
    step(1'b0, 1'b0, '0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL drop_restart: got busy %b want 1", busy); end
    run_to_done(200, to2);
    checks++;
    if (to1 || to2 || done_cnt != 2 || an_cnt != 2 * NPIX || an_bad != 0 || short_sweeps != 0) begin
      errors++; $display("FAIL drop_two_sweeps: got done %0d pixels %0d bad %0d want 2 %0d 0",
                         done_cnt, an_cnt, an_bad, 2 * NPIX);
    end
    // Frame arriving on the DONE cycle is queued, not dropped
    step(1'b1, 1'b0, '0);
    checks++;
    if (busy !== 1'b0 || frames_dropped !== 8'd2) begin
      errors++; $display("FAIL done_collision: got busy %b dropped %0d want 0 2", busy, frames_dropped);
    end
    step(1'b0, 1'b0, '0);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL done_collision_restart: got busy %b want 1", busy); end
    for (int p = 1; p <= 300; p++) begin
      step(1'b0, 1'b1, AW'($urandom));
      step(1'b1, 1'b1, AW'($urandom));
      if (p == 100) begin
        checks++;
        if (frames_dropped !== 8'd101) begin errors++; $display("FAIL drop_count_mid: got %0d want 101", frames_dropped); end
      end
    end
    checks++;
    if (frames_dropped !== 8'd255) begin errors++; $display("FAIL drop_saturate: got %0d want 255", frames_dropped); end
    run_to_done(200, to1);
    run_to_done(200, to2);
    checks++;
    if (to1 || to2 || done_cnt != 4 || an_cnt != 4 * NPIX || an_bad != 0 || vga_bad != 0 || frames_dropped !== 8'd255) begin
      errors++; $display("FAIL drop_tail: got done %0d pixels %0d bad %0d vga_bad %0d dropped %0d want 4 %0d 0 0 255",
                         done_cnt, an_cnt, an_bad, vga_bad, frames_dropped, 4 * NPIX);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int ghost;
    bit to;
    ghost = 0;
    clear_obs();
    step(1'b1, 1'b0, '0);
    for (int k = 1; k <= 17; k++) step(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    checks++;
    if (all_outs() !== '0) begin errors++; $display("FAIL midreset_outputs: got %h want 0", all_outs()); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    clear_obs();
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, '0);
      if (an_valid || vga_valid || busy) ghost++;
    end
    checks++;
    if (ghost != 0 || frames_dropped !== 8'd0) begin
      errors++; $display("FAIL midreset_ghost: got %0d stray cycles dropped %0d want 0 0", ghost, frames_dropped);
    end
    step(1'b1, 1'b0, '0);
    run_to_done(200, to);
    checks++;
    if (to || an_cnt != NPIX || an_bad != 0 || short_sweeps != 0) begin
      errors++; $display("FAIL midreset_restart: got timeout %b pixels %0d bad %0d want 0 %0d 0", to, an_cnt, an_bad, NPIX);
    end
  endtask

  initial begin
    fill_mem();
    test_reset();
    test_sweep();
    test_vga_interleave();
    test_vga_stall();
    test_drop_frames();
    test_reset_mid_sweep();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
